pmul_seq: RTL and testbench

PMUL_SEQ -- requirements
Module: pmul_seq

---
 rtl/pmul_seq.sv | 152 +++++++++++++++
 tb/tb_pmul_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmul_seq.sv
// Sequential W x W -> 2W multiplier fed from a CPU write queue, result returned to a read queue.
// Optional build macro PMUL_SIGNED_EN enables signed mode (sgn); without it every operation is unsigned.
module pmul_seq #(
    parameter int W    = 32,
    parameter int LIMB = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] wq,
    output logic         rwq,
    output logic [W-1:0] rq,
    output logic         wrq,
    input  logic         rqFull,
    input  logic         selMul,
    input  logic         sgn,
    output logic         done,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    localparam int N  = W / LIMB;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDB  = 3'd1,
        MUL  = 3'd2,
        FIX  = 3'd3,
        WRLO = 3'd4,
        WRHI = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_q, b_q;
    logic            mode_q;
    logic [PW-1:0]   p_q;
    logic [KW-1:0]   k_q;
    logic            rst_q;

    logic            start;
    logic [W-1:0]    abs_a, abs_b;
    logic [LIMB-1:0] limb;
    logic [W+LIMB-1:0] pp;
    logic [PW-1:0]   addend;
    logic            neg_res;

    // Magnitudes are W-bit unsigned, so the most negative operand maps onto itself without overflow.
    always_comb begin
        abs_a   = (mode_q && a_q[W-1]) ? (-a_q) : a_q;
        abs_b   = (mode_q && b_q[W-1]) ? (-b_q) : b_q;
        limb    = abs_b[k_q*LIMB +: LIMB];
        pp      = {{LIMB{1'b0}}, abs_a} * {{W{1'b0}}, limb};
        addend  = PW'(pp) << (k_q * LIMB);
        neg_res = mode_q && (a_q[W-1] ^ b_q[W-1]);
    end

    // A start request in the cycle right after reset is dropped so that cycle stays quiet.
    assign start = selMul && !rst_q;

    always_ff @(posedge clock) begin
        rst_q <= reset;
        if (reset) begin
            state  <= IDLE;
            k_q    <= '0;
            p_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= wq;
`ifdef PMUL_SIGNED_EN
                        mode_q <= sgn;
`else
                        // sgn is read but has no effect in an unsigned-only build.
                        mode_q <= sgn & 1'b0;
`endif
                    end
                end
                LDB: begin
                    b_q <= wq;
                    p_q <= '0;
                    k_q <= '0;
                end
                MUL: begin
                    p_q <= p_q + addend;
                    k_q <= k_q + KW'(1);
                end
                FIX: begin
                    if (neg_res) p_q <= -p_q;
                end
                default: ;
            endcase
        end
    end

    // Queue handshakes: rwq pops the entry presented on wq in the same cycle; wrq pushes rq
    // in the same cycle and is only raised while rqFull is low, so a push always lands.
    always_comb begin
        state_nx = state;
        rwq      = 1'b0;
        wrq      = 1'b0;
        done     = 1'b0;
        rq       = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    rwq      = 1'b1;
                    state_nx = LDB;
                end
            end
            LDB: begin
                rwq      = 1'b1;
                state_nx = MUL;
            end
            MUL: begin
                if (k_q == KW'(N - 1)) state_nx = FIX;
            end
            FIX: state_nx = WRLO;
            WRLO: begin
                if (!rqFull) begin
                    wrq      = 1'b1;
                    rq       = p_q[W-1:0];
                    state_nx = WRHI;
                end
            end
            WRHI: begin
                if (!rqFull) begin
                    wrq      = 1'b1;
                    done     = 1'b1;
                    rq       = p_q[PW-1:W];
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (reset) begin
            rwq  = 1'b0;
            wrq  = 1'b0;
            done = 1'b0;
            rq   = '0;
        end
    end

    assign busy      = (state != IDLE) && !reset;
    assign dbg_state = state;

endmodule

// File: tb/tb_pmul_seq.sv
// Directed bench for pmul_seq: a W=32 instance for most scenarios and a W=64 instance for the wide case.
module tb_pmul_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] wq32 = '0;
    logic [31:0] rq32;
    logic        rwq32, wrq32, done32, busy32;
    logic        full32 = 1'b0, sel32 = 1'b0, sgn32 = 1'b0;
    logic [2:0]  st32;

    logic [63:0] wq64 = '0;
    logic [63:0] rq64;
    logic        rwq64, wrq64, done64, busy64;
    logic        full64 = 1'b0, sel64 = 1'b0, sgn64 = 1'b0;
    logic [2:0]  st64;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pmul_seq #(.W(32), .LIMB(16)) dut32 (
        .clock(clock), .reset(reset), .wq(wq32), .rwq(rwq32), .rq(rq32), .wrq(wrq32),
        .rqFull(full32), .selMul(sel32), .sgn(sgn32), .done(done32), .busy(busy32),
        .dbg_state(st32)
    );

    pmul_seq #(.W(64), .LIMB(16)) dut64 (
        .clock(clock), .reset(reset), .wq(wq64), .rwq(rwq64), .rq(rq64), .wrq(wrq64),
        .rqFull(full64), .selMul(sel64), .sgn(sgn64), .done(done64), .busy(busy64),
        .dbg_state(st64)
    );

    // One operation: cycle 0 is the selMul cycle; stall holds rqFull for that many cycles from WRLO entry.
    task automatic run_op(input string name, input bit wide, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input int stall, input bit hold,
                          input logic [63:0] elo, input logic [63:0] ehi);
        logic [63:0] ops [2];
        logic [63:0] wqv, got_lo, got_hi, o_rq;
        logic        o_rwq, o_wrq, o_done, selv, fullv;
        int idx = 0, lo_c = -1, done_c = -1, nwr = 0, rq_bad = 0, rwq_late = 0, base;
        bit fin = 0;
        got_lo = '0;
        got_hi = '0;
        ops[0] = a;
        ops[1] = b;
        base = wide ? 7 : 5;
        for (int c = 0; c < 60 && !fin; c++) begin
            selv  = (c == 0) || (hold && done_c < 0);
            fullv = (c >= base) && (c < base + stall);
            wqv   = (idx < 2) ? ops[idx] : 64'hA5A5_5A5A_C3C3_3C3C;
            if (wide) begin
                sel64 = selv; sgn64 = s; full64 = fullv; wq64 = wqv;
            end else begin
                sel32 = selv; sgn32 = s; full32 = fullv; wq32 = wqv[31:0];
            end
            @(negedge clock);
            o_rwq  = wide ? rwq64 : rwq32;
            o_wrq  = wide ? wrq64 : wrq32;
            o_done = wide ? done64 : done32;
            o_rq   = wide ? rq64 : {32'd0, rq32};
            if (o_rwq) begin
                if (c > 1) rwq_late++;
                idx++;
            end
            if (!o_wrq && o_rq != '0) rq_bad++;
            if (o_wrq) begin
                nwr++;
                if (nwr == 1) begin
                    got_lo = o_rq;
                    lo_c   = c;
                end else begin
                    got_hi = o_rq;
                end
            end
            if (o_done) begin
                done_c = c;
                fin    = 1;
            end
            @(posedge clock);
            #1;
        end
        sel32 = 1'b0; full32 = 1'b0; sel64 = 1'b0; full64 = 1'b0;

        checks++;
        if (got_lo !== elo) begin
            failures++;
            $display("FAIL %s low_word: got %h want %h", name, got_lo, elo);
        end
        checks++;
        if (got_hi !== ehi) begin
            failures++;
            $display("FAIL %s high_word: got %h want %h", name, got_hi, ehi);
        end
        checks++;
        if (lo_c != base + stall) begin
            failures++;
            $display("FAIL %s low_cycle: got %0d want %0d", name, lo_c, base + stall);
        end
        checks++;
        if (done_c != base + 1 + stall) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_c, base + 1 + stall);
        end
        checks++;
        if (idx != 2 || rwq_late != 0) begin
            failures++;
            $display("FAIL %s pops: got %0d (late %0d) want 2 (late 0)", name, idx, rwq_late);
        end
        checks++;
        if (nwr != 2) begin
            failures++;
            $display("FAIL %s writes: got %0d want 2", name, nwr);
        end
        checks++;
        if (rq_bad != 0) begin
            failures++;
            $display("FAIL %s rq_nonzero_without_wrq: got %0d cycles want 0", name, rq_bad);
        end
    endtask

    task automatic test_reset();
        logic [35:0] v32_in, v32_after;
        logic [67:0] v64_in;
        reset = 1'b1;
        sel32 = 1'b1; sel64 = 1'b1;
        wq32 = 32'h1234_5678; wq64 = 64'h1;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        v32_in = {rwq32, wrq32, done32, busy32, rq32};
        v64_in = {rwq64, wrq64, done64, busy64, rq64};
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        v32_after = {rwq32, wrq32, done32, busy32, rq32};
        @(posedge clock);
        #1;
        sel32 = 1'b0; sel64 = 1'b0;
        checks++;
        if (v32_in !== '0) begin
            failures++;
            $display("FAIL reset_cycle_outputs32: got %h want 0", v32_in);
        end
        checks++;
        if (v64_in !== '0) begin
            failures++;
            $display("FAIL reset_cycle_outputs64: got %h want 0", v64_in);
        end
        checks++;
        if (v32_after !== '0) begin
            failures++;
            $display("FAIL post_reset_outputs32: got %h want 0", v32_after);
        end
        checks++;
        if (st32 !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_state: got %0d want 0", st32);
        end
    endtask

    task automatic test_unsigned();
        run_op("u_max", 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 0, 0, 64'h0000_0001, 64'hFFFF_FFFE);
        run_op("u_limb_shift", 0, 64'h0001_0000, 64'h0001_0000, 1'b0, 0, 0, 64'h0, 64'h1);
        run_op("u_limb_mix", 0, 64'h0000_FFFF, 64'h0001_0001, 1'b0, 0, 0, 64'hFFFF_FFFF, 64'h0);
    endtask

    task automatic test_signed();
`ifdef PMUL_SIGNED_EN
        run_op("s_neg1_x2", 0, 64'hFFFF_FFFF, 64'h2, 1'b1, 0, 0, 64'hFFFF_FFFE, 64'hFFFF_FFFF);
        run_op("s_3_xneg5", 0, 64'h3, 64'hFFFF_FFFB, 1'b1, 0, 0, 64'hFFFF_FFF1, 64'hFFFF_FFFF);
`else
        run_op("s_neg1_x2", 0, 64'hFFFF_FFFF, 64'h2, 1'b1, 0, 0, 64'hFFFF_FFFE, 64'h1);
        run_op("s_3_xneg5", 0, 64'h3, 64'hFFFF_FFFB, 1'b1, 0, 0, 64'hFFFF_FFF1, 64'h2);
`endif
        run_op("s_min_sq", 0, 64'h8000_0000, 64'h8000_0000, 1'b1, 0, 0, 64'h0, 64'h4000_0000);
        run_op("u_neg_operand", 0, 64'hFFFF_FFFF, 64'h2, 1'b0, 0, 0, 64'hFFFF_FFFE, 64'h1);
    endtask

    task automatic test_stall();
        run_op("stall3", 0, 64'h3, 64'h5, 1'b0, 3, 0, 64'hF, 64'h0);
    endtask

    task automatic test_busy_ignore();
        run_op("sel_held_busy", 0, 64'h6, 64'h7, 1'b0, 0, 1, 64'h2A, 64'h0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 0, 64'h10, 64'h10, 1'b0, 0, 0, 64'h100, 64'h0);
        run_op("b2b_second", 0, 64'h2, 64'h8000_0000, 1'b0, 0, 0, 64'h0, 64'h1);
    endtask

    task automatic test_reset_abort();
        int wr = 0;
        logic busy_mid = 1'b0;
        logic [35:0] v_rst, v_after;
        v_rst = '0;
        v_after = '0;
        sgn32 = 1'b0; full32 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            reset = (c == 3);
            sel32 = (c <= 4);
            wq32  = (c == 0) ? 32'd7 : 32'd9;
            @(negedge clock);
            if (wrq32) wr++;
            if (c == 2) busy_mid = busy32;
            if (c == 3) v_rst = {rwq32, wrq32, done32, busy32, rq32};
            if (c == 4) v_after = {rwq32, wrq32, done32, busy32, rq32};
            @(posedge clock);
            #1;
        end
        reset = 1'b0; sel32 = 1'b0;
        checks++;
        if (busy_mid !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before_reset: got %b want 1", busy_mid);
        end
        checks++;
        if (v_rst !== '0) begin
            failures++;
            $display("FAIL abort_reset_cycle: got %h want 0", v_rst);
        end
        checks++;
        if (v_after !== '0) begin
            failures++;
            $display("FAIL abort_post_reset_cycle: got %h want 0", v_after);
        end
        checks++;
        if (wr != 0) begin
            failures++;
            $display("FAIL abort_writes: got %0d want 0", wr);
        end
        checks++;
        if (st32 !== 3'd0) begin
            failures++;
            $display("FAIL abort_state: got %0d want 0", st32);
        end
        run_op("abort_recover", 0, 64'h3, 64'h5, 1'b0, 0, 0, 64'hF, 64'h0);
    endtask

    task automatic test_wide();
        run_op("w64_max_x2", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0, 0, 0,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_stall();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
